nx_fifo_rd_adapter: RTL and testbench

// - Read-side unloader for an nx_fifo instance. Drives the FIFO's ren from its empty flag and

---
 rtl/nx_fifo_rd_adapter.sv | 129 ++++++++++++
 tb/tb_nx_fifo_rd_adapter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_rd_adapter.sv
// Read-side unloader for an nx_fifo: pops on !empty into a 2-entry skid and presents a registered valid/ready stream.
// Optional stats counters under `NX_FIFO_RD_ADAPTER_STATS_EN`; one word per cycle, no out_ready->fifo_ren path.
module nx_fifo_rd_adapter #(
  parameter int WIDTH      = 132,
  parameter bit DATA_RESET = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic             idle,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             pop;
  logic             ld0_fifo;
  logic             ld0_shift;
  logic             ld1;

  // Pop decision depends only on registered occupancy, never on out_ready.
  assign fifo_ren  = !fifo_empty && !clear && (state != S2);
  assign out_valid = (state != S0);
  assign out_data  = entry0;
  assign occupancy = state;
  assign idle      = (state == S0) && fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld0_fifo  = 1'b0;
    ld0_shift = 1'b0;
    ld1       = 1'b0;
    if (clear) begin
      state_nxt = S0;
    end else begin
      case (state)
        S0: if (fifo_ren) begin
          state_nxt = S1;
          ld0_fifo  = 1'b1;
        end
        S1: begin
          if (fifo_ren && pop) begin
            ld0_fifo = 1'b1;
          end else if (fifo_ren) begin
            state_nxt = S2;
            ld1       = 1'b1;
          end else if (pop) begin
            state_nxt = S0;
          end
        end
        S2: if (pop) begin
          state_nxt = S1;
          ld0_shift = 1'b1;
        end
        default: state_nxt = S0;
      endcase
    end
  end

  generate
    if (DATA_RESET) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry0 <= '0;
          entry1 <= '0;
        end else begin
          if (ld0_fifo)       entry0 <= fifo_rdata;
          else if (ld0_shift) entry0 <= entry1;
          if (ld1)            entry1 <= fifo_rdata;
        end
      end
    end else begin : g_data_nrst
      always_ff @(posedge clk) begin
        if (ld0_fifo)       entry0 <= fifo_rdata;
        else if (ld0_shift) entry0 <= entry1;
        if (ld1)            entry1 <= fifo_rdata;
      end
    end
  endgenerate

`ifdef NX_FIFO_RD_ADAPTER_STATS_EN
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] stall_q;

  // Saturating counters; clear wins over any handshake in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else if (clear) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && out_ready && (beat_q != '1))   beat_q  <= beat_q + 1'b1;
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_rd_adapter.sv
// Directed bench for nx_fifo_rd_adapter with a queue-based FIFO model on the read side.
module tb_nx_fifo_rd_adapter;
  localparam int W = 132;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata;
  logic          fifo_ren;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic          idle;
  logic [31:0]   beat_cnt;
  logic [31:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic         hide;

  logic         s_ren, s_vld, s_hs, s_empty, s_idle;
  logic [W-1:0] s_dat;
  logic [1:0]   s_occ;

  always #5 clk = ~clk;

  nx_fifo_rd_adapter #(.WIDTH(W), .DATA_RESET(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
    .idle(idle), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
  );

`ifdef NX_FIFO_RD_ADAPTER_STATS_EN
  logic          sat_ren, sat_vld, sat_idle;
  logic [W-1:0]  sat_dat;
  logic [1:0]    sat_occ;
  logic [3:0]    sat_beat, sat_stall;

  nx_fifo_rd_adapter #(.WIDTH(W), .DATA_RESET(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_ren(sat_ren), .out_valid(sat_vld),
    .out_ready(out_ready), .out_data(sat_dat), .occupancy(sat_occ),
    .idle(sat_idle), .beat_cnt(sat_beat), .stall_cnt(sat_stall)
  );
`endif

  function automatic logic [W-1:0] word(input int n);
    logic [31:0] v;
    v = n;
    return {4'hA, 96'd0, v};
  endfunction

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0) || hide;
    fifo_rdata = (q.size() != 0) ? q[0] : '0;
  endtask

  // Sample at negedge, advance one edge, then update the FIFO model at posedge+1.
  task automatic tick();
    @(negedge clk);
    s_ren   = fifo_ren;
    s_vld   = out_valid;
    s_dat   = out_data;
    s_occ   = occupancy;
    s_idle  = idle;
    s_empty = fifo_empty;
    s_hs    = out_valid && out_ready && !clear;
    @(posedge clk);
    #1;
    if (s_ren && q.size() != 0) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    drive_fifo();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; hide = 1'b0;
    q.delete();
    drive_fifo();
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_ren !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_vals: valid=%b ren=%b occ=%0d data=%h, required 0 0 0 0",
               out_valid, fifo_ren, occupancy, out_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (s_vld !== 1'b0 || s_ren !== 1'b0 || s_occ !== 2'd0 || s_idle !== 1'b1) begin
        errors++;
        $display("FAIL idle_cyc%0d: valid=%b ren=%b occ=%0d idle=%b, required 0 0 0 1",
                 i, s_vld, s_ren, s_occ, s_idle);
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) q.push_back(word(i));
    out_ready = 1'b1;
    drive_fifo();
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (s_ren !== (t < 8)) begin
        errors++;
        $display("FAIL stream_ren t%0d: got %b, required %b", t, s_ren, (t < 8));
      end
      if (t >= 1 && t <= 8) begin
        checks++;
        if (s_vld !== 1'b1 || s_dat !== word(t) || s_occ !== 2'd1) begin
          errors++;
          $display("FAIL stream_out t%0d: valid=%b data=%h occ=%0d, required 1 %h 1",
                   t, s_vld, s_dat, s_occ, word(t));
        end
      end
    end
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: occ=%0d valid=%b, required 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_back_pressure();
    int rens;
    rens = 0;
    for (int i = 0; i < 6; i++) q.push_back(word(16'h11 + i));
    out_ready = 1'b0;
    drive_fifo();
    for (int t = 0; t < 5; t++) begin
      tick();
      if (s_ren) rens++;
      if (t >= 1) begin
        checks++;
        if (s_vld !== 1'b1 || s_dat !== word(16'h11)) begin
          errors++;
          $display("FAIL bp_hold t%0d: valid=%b data=%h, required 1 %h", t, s_vld, s_dat, word(16'h11));
        end
      end
    end
    checks++;
    if (rens != 2 || occupancy !== 2'd2) begin
      errors++;
      $display("FAIL bp_rens: rens=%0d occ=%0d, required 2 2", rens, occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_vld !== 1'b1 || s_dat !== word(16'h11 + i)) begin
        errors++;
        $display("FAIL bp_release%0d: valid=%b data=%h, required 1 %h", i, s_vld, s_dat, word(16'h11 + i));
      end
    end
    tick();
    checks++;
    if (s_vld !== 1'b0 || s_occ !== 2'd0) begin
      errors++;
      $display("FAIL bp_end: valid=%b occ=%0d, required 0 0", s_vld, s_occ);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) q.push_back(word(16'h40 + i));
    out_ready = 1'b0;
    drive_fifo();
    tick(); tick();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL clr_setup: occ=%0d, required 2", occupancy);
    end
    out_ready = 1'b1;
    do_clear();
    checks++;
    if (s_ren !== 1'b0) begin
      errors++;
      $display("FAIL clr_ren: got %b in clear cycle, required 0", s_ren);
    end
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || beat_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL clr_after: occ=%0d valid=%b beats=%0d stalls=%0d, required 0 0 0 0",
               occupancy, out_valid, beat_cnt, stall_cnt);
    end
    // Asynchronous reset mid-stream drops skid contents immediately.
    out_ready = 1'b0;
    q.push_back(word(16'h77));
    q.push_back(word(16'h78));
    drive_fifo();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL arst_mid: valid=%b occ=%0d data=%h ren=%b, required 0 0 0 0",
               out_valid, occupancy, out_data, fifo_ren);
    end
    q.delete();
    drive_fifo();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int pushed, next_exp, bad_ren, bad_ord;
    pushed = 0; next_exp = 0; bad_ren = 0; bad_ord = 0;
    for (int t = 0; t < 10000; t++) begin
      if (q.size() < 8 && $urandom_range(0, 1) == 1) begin
        q.push_back(word(pushed));
        pushed++;
      end
      hide      = ($urandom_range(0, 3) == 0);
      out_ready = $urandom_range(0, 1);
      drive_fifo();
      tick();
      if (s_ren && s_empty) bad_ren++;
      if (s_hs) begin
        if (s_dat !== word(next_exp)) begin
          bad_ord++;
          if (bad_ord < 5)
            $display("FAIL rand_order: got %h, required %h", s_dat, word(next_exp));
        end
        next_exp++;
      end
    end
    hide = 1'b0;
    out_ready = 1'b1;
    drive_fifo();
    for (int t = 0; t < 50 && next_exp < pushed; t++) begin
      tick();
      if (s_hs) begin
        if (s_dat !== word(next_exp)) bad_ord++;
        next_exp++;
      end
    end
    checks++;
    if (bad_ren != 0) begin
      errors++;
      $display("FAIL rand_underflow: %0d pops of empty FIFO, required 0", bad_ren);
    end
    checks++;
    if (bad_ord != 0) begin
      errors++;
      $display("FAIL rand_scoreboard: %0d order errors, required 0", bad_ord);
    end
    checks++;
    if (next_exp != pushed || pushed < 100) begin
      errors++;
      $display("FAIL rand_count: received %0d of %0d pushed", next_exp, pushed);
    end
  endtask

  task automatic test_stats();
    int acc;
    acc = 0;
    do_clear();
    for (int i = 0; i < 100; i++) q.push_back(word(16'h200 + i));
    out_ready = 1'b0;
    drive_fifo();
    tick();
    for (int i = 0; i < 37; i++) tick();
    out_ready = 1'b1;
    for (int t = 0; t < 300 && acc < 100; t++) begin
      tick();
      if (s_hs) acc++;
    end
    out_ready = 1'b0;
    checks++;
    if (acc != 100) begin
      errors++;
      $display("FAIL stats_accepts: %0d accepted within bound, required 100", acc);
    end
`ifdef NX_FIFO_RD_ADAPTER_STATS_EN
    checks++;
    if (beat_cnt !== 32'd100 || stall_cnt !== 32'd37) begin
      errors++;
      $display("FAIL stats_cnt: beats=%0d stalls=%0d, required 100 37", beat_cnt, stall_cnt);
    end
    checks++;
    if (sat_beat !== 4'd15 || sat_stall !== 4'd15) begin
      errors++;
      $display("FAIL stats_sat: beats=%0d stalls=%0d, required 15 15", sat_beat, sat_stall);
    end
`else
    checks++;
    if (beat_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_tied: beats=%0d stalls=%0d, required 0 0", beat_cnt, stall_cnt);
    end
`endif
    do_clear();
    checks++;
    if (beat_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear: beats=%0d stalls=%0d, required 0 0", beat_cnt, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_clear();
    test_random();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
